// File: rtl/snappy_axi_pkg.sv
// Shared AXI encodings and burst-length type for the read burst issuer.
package snappy_axi_pkg;

    localparam logic [2:0]  AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned BEATS_PER_4K   = 64;

    // beats-1 field; wide enough for a 4 KB burst plus wrap headroom in the checker
    localparam int unsigned LEN_W = $clog2(BEATS_PER_4K) + 2;
    typedef logic [LEN_W-1:0] beat_len_t;

endpackage

// File: rtl/burst_len_fifo.sv
// FIFO of issued burst lengths; head is registered so the beat checker sees a flop output.
module burst_len_fifo
    import snappy_axi_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  beat_len_t din_i,
    input  logic      pop_i,
    output beat_len_t head_o,
    output logic      empty_o,
    output logic      full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    beat_len_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    beat_len_t        head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = head_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // head follows the entry behind the popped one, or the incoming word when that slot was empty
        if (do_pop) begin
            if (count_q == (PTR_W+1)'(1)) head_d = din_i;
            else                           head_d = mem_q[rd_ptr_d];
        end else if (do_push && empty_o) begin
            head_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/axi_rd_burst_issuer.sv
// Turns upstream burst read requests into AXI AR transactions, forwards R data
// to the decompressor and checks returned beat counts against issued lengths.
module axi_rd_burst_issuer
    import snappy_axi_pkg::*;
#(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned MAX_OUTSTANDING = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_req,
    input  logic [7:0]        rd_len,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_req_ack,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err_len,
    output logic              err_resp
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    beat_len_t         arlen_q, arlen_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    beat_len_t         beat_cnt_q, beat_cnt_d;
    logic              err_len_q, err_len_d;
    logic              err_resp_q, err_resp_d;

    logic              fifo_empty, fifo_full;
    beat_len_t         fifo_head;
    logic              beat, fifo_pop;

    // registered count only, so a same-cycle pop never frees a slot early
    assign rd_req_ack = rst_n & rd_req & ~arvalid_q & ~fifo_full
                      & (outstanding_q < CNT_W'(MAX_OUTSTANDING));

    assign beat     = rvalid & m_ready;
    assign fifo_pop = beat & rlast & ~fifo_empty;

    assign m_valid  = rvalid;
    assign rready   = m_ready;
    assign m_data   = rdata;
    assign m_last   = rlast;

    assign arvalid  = arvalid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = AXI_SIZE_64B;
    assign arburst  = AXI_BURST_INCR;
    assign busy     = (outstanding_q != '0);
    assign err_len  = err_len_q;
    assign err_resp = err_resp_q;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        if (rd_req_ack) begin
            arvalid_d = 1'b1;
            araddr_d  = rd_address;
            arlen_d   = rd_len;
        end else if (arvalid_q && arready) begin
            arvalid_d = 1'b0;
        end
    end

    always_comb begin
        case ({rd_req_ack, fifo_pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        err_len_d  = err_len_q & ~start;
        err_resp_d = err_resp_q & ~start;
        if (beat) begin
            if (rresp != 2'b00) err_resp_d = 1'b1;
            if (fifo_empty) begin
                err_len_d = 1'b1;
            end else if (rlast) begin
                if (beat_cnt_q != fifo_head) err_len_d = 1'b1;
                beat_cnt_d = '0;
            end else begin
                if (beat_cnt_q == fifo_head) err_len_d = 1'b1;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            err_len_q     <= 1'b0;
            err_resp_q    <= 1'b0;
        end else begin
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            err_len_q     <= err_len_d;
            err_resp_q    <= err_resp_d;
        end
    end

    burst_len_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_req_ack),
        .din_i   (rd_len),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_axi_rd_burst_issuer.sv
// Directed and randomized bench for axi_rd_burst_issuer against a queue-based reference model.
module tb_axi_rd_burst_issuer;
    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, rd_req, rd_req_ack;
    logic [7:0]    rd_len, arlen;
    logic [AW-1:0] rd_address, araddr;
    logic          arvalid, arready;
    logic [2:0]    arsize;
    logic [1:0]    arburst, rresp;
    logic          rvalid, rready, rlast;
    logic [DW-1:0] rdata, m_data;
    logic          m_valid, m_ready, m_last, busy, err_len, err_resp;

    always #5 clk = ~clk;

    axi_rd_burst_issuer #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_req(rd_req), .rd_len(rd_len), .rd_address(rd_address), .rd_req_ack(rd_req_ack),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err_len(err_len), .err_resp(err_resp)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } req_t;
    typedef struct { logic last; logic [1:0] resp; } beat_t;

    int vectors = 0, miscompares = 0, cyc = 0;
    req_t  req_q[$];
    beat_t beat_q[$];
    int arready_pol = 1, mready_pol = 1, rvalid_pol = 1;   // 0 low, 1 high, 2 random

    // reference model: bursts in flight as a list of lengths
    logic [7:0]    mdl_lens[$];
    int            mdl_beats;
    bit            mdl_arvalid, mdl_err_len, mdl_err_resp;
    logic [AW-1:0] mdl_araddr;
    logic [7:0]    mdl_arlen;
    logic [AW-1:0] exp_ar_order[$];

    int n_ack = 0, n_beats = 0, n_last = 0, last_beat_cyc = 0, last_ack_cyc = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait budget expired", tag);
    endtask

    function automatic logic pol(input int p);
        return (p == 2) ? logic'($urandom_range(0, 1)) : (p == 1);
    endfunction

    task automatic mdl_reset();
        mdl_lens.delete();
        exp_ar_order.delete();
        mdl_beats = 0; mdl_arvalid = 0; mdl_err_len = 0; mdl_err_resp = 0;
        mdl_araddr = '0; mdl_arlen = '0;
    endtask

    task automatic tick();
        bit exp_ack, hs, bt;
        rd_req = (req_q.size() > 0);
        if (rd_req) begin rd_len = req_q[0].len; rd_address = req_q[0].addr; end
        arready = pol(arready_pol);
        m_ready = pol(mready_pol);
        rvalid  = (beat_q.size() > 0) && pol(rvalid_pol);
        if (beat_q.size() > 0) begin rlast = beat_q[0].last; rresp = beat_q[0].resp; end
        else begin rlast = 0; rresp = 0; end
        for (int i = 0; i < DW / 32; i++) rdata[i*32 +: 32] = $urandom();
        #1;
        exp_ack = rst_n && rd_req && !mdl_arvalid && (mdl_lens.size() < MAXO);
        chk("rd_req_ack", rd_req_ack, exp_ack);
        chk("m_valid", m_valid, rvalid);
        chk("rready", rready, m_ready);
        chk("m_last", m_last, rlast);
        chk("m_data", m_data, rdata);
        hs = mdl_arvalid && arready;
        bt = rvalid && m_ready;
        if (rst_n && hs && exp_ar_order.size() > 0) chk("ar_order", araddr, exp_ar_order.pop_front());
        if (rd_req_ack) begin n_ack++; last_ack_cyc = cyc; void'(req_q.pop_front()); end
        if (bt) begin
            n_beats++;
            if (rlast) begin n_last++; last_beat_cyc = cyc; end
            void'(beat_q.pop_front());
        end
        if (!rst_n) mdl_reset();
        else begin
            if (start) begin mdl_err_len = 0; mdl_err_resp = 0; end
            if (bt) begin
                if (rresp != 2'b00) mdl_err_resp = 1;
                if (mdl_lens.size() == 0) mdl_err_len = 1;
                else if (rlast) begin
                    if (mdl_beats != int'(mdl_lens[0])) mdl_err_len = 1;
                    void'(mdl_lens.pop_front());
                    mdl_beats = 0;
                end else begin
                    if (mdl_beats == int'(mdl_lens[0])) mdl_err_len = 1;
                    mdl_beats = (mdl_beats + 1) % 256;
                end
            end
            if (hs) mdl_arvalid = 0;
            if (exp_ack) begin
                mdl_arvalid = 1; mdl_araddr = rd_address; mdl_arlen = rd_len;
                mdl_lens.push_back(rd_len);
                exp_ar_order.push_back(rd_address);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("arvalid", arvalid, mdl_arvalid);
        chk("araddr", araddr, mdl_araddr);
        chk("arlen", arlen, mdl_arlen);
        chk("arsize", arsize, 3'b110);
        chk("arburst", arburst, 2'b01);
        chk("busy", busy, mdl_lens.size() != 0);
        chk("err_len", err_len, mdl_err_len);
        chk("err_resp", err_resp, mdl_err_resp);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic add_req(input logic [AW-1:0] a, input logic [7:0] l);
        req_t r; r.addr = a; r.len = l; req_q.push_back(r);
    endtask

    task automatic add_beats(input int n, input int bad_resp_idx);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.last = (i == n - 1);
            b.resp = (i == bad_resp_idx) ? 2'b10 : 2'b00;
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_reqs(input string tag, input int budget);
        int k = 0;
        while (req_q.size() > 0 && k < budget) begin tick(); k++; end
        if (req_q.size() > 0) timeout(tag);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((beat_q.size() > 0 || req_q.size() > 0) && k < budget) begin tick(); k++; end
        if (beat_q.size() > 0 || req_q.size() > 0) timeout(tag);
        run(2);
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    initial begin
        int a0, b0, l0, k;
        logic [7:0] lens9[9];
        rst_n = 0; start = 0; rd_req = 0; rd_len = 0; rd_address = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0; m_ready = 0;
        mdl_reset();

        // reset with a request already pending: no ack until reset releases
        add_req(64'h1000, 8'd4);
        run(3);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1;

        // single 5-beat burst
        wait_reqs("t1_ack", 5);
        chk("t1_araddr", araddr, 64'h1000);
        chk("t1_arlen", arlen, 8'd4);
        chk("t1_busy_hi", busy, 1'b1);
        l0 = n_last;
        add_beats(5, -1);
        drain("t1_drain", 50);
        chk("t1_one_mlast", n_last - l0, 1);
        chk("t1_busy_lo", busy, 1'b0);
        chk("t1_no_err", {err_len, err_resp}, 2'b00);

        // three 4 KB bursts with AR stalled for 10 cycles
        arready_pol = 0;
        a0 = n_ack;
        add_req(64'h0, 8'd63); add_req(64'h1000, 8'd63); add_req(64'h2000, 8'd63);
        run(10);
        chk("t2_one_ack_stalled", a0 == 0 ? n_ack : n_ack - a0, 1);
        arready_pol = 1;
        wait_reqs("t2_acks", 20);
        b0 = n_beats;
        rvalid_pol = 2; mready_pol = 2;
        add_beats(64, -1); add_beats(64, -1); add_beats(64, -1);
        drain("t2_drain", 3000);
        chk("t2_beats", n_beats - b0, 192);
        chk("t2_no_err", err_len, 1'b0);

        // fill to the outstanding limit, ninth request waits for a pop
        rvalid_pol = 1; mready_pol = 1;
        a0 = n_ack;
        for (int i = 0; i < 9; i++) begin
            lens9[i] = 8'($urandom_range(0, 15));
            add_req(64'(i + 16) << 12, lens9[i]);
        end
        run(30);
        chk("t3_eight_acks", n_ack - a0, 8);
        chk("t3_ninth_waits", req_q.size(), 1);
        add_beats(int'(lens9[0]) + 1, -1);
        wait_reqs("t3_ninth_ack", 100);
        chk("t3_ack_after_pop", last_ack_cyc - last_beat_cyc, 1);
        rvalid_pol = 2; mready_pol = 2;
        for (int i = 1; i < 9; i++) add_beats(int'(lens9[i]) + 1, -1);
        drain("t3_drain", 2000);
        chk("t3_busy_lo", busy, 1'b0);

        // short burst flags err_len, start clears it
        rvalid_pol = 1; mready_pol = 1;
        add_req(64'h5000, 8'd3);
        wait_reqs("t4_ack", 5);
        add_beats(3, -1);
        drain("t4_drain", 30);
        chk("t4_err_len", err_len, 1'b1);
        pulse_start();
        chk("t4_cleared", err_len, 1'b0);

        // error response still forwarded
        add_req(64'h6000, 8'd1);
        wait_reqs("t5_ack", 5);
        add_beats(2, 0);
        drain("t5_drain", 30);
        chk("t5_err_resp", err_resp, 1'b1);
        chk("t5_len_ok", err_len, 1'b0);
        pulse_start();
        chk("t5_cleared", err_resp, 1'b0);

        // backpressure mid-burst, then ack coinciding with the final pop
        add_req(64'h7000, 8'd7);
        wait_reqs("t6_ack", 5);
        add_beats(8, -1);
        run(3);
        mready_pol = 0;
        run(5);
        chk("t6_no_beats_lost", beat_q.size(), 5);
        mready_pol = 1;
        k = 0;
        while (beat_q.size() > 1 && k < 20) begin tick(); k++; end
        if (beat_q.size() != 1) timeout("t6_wait_last");
        add_req(64'h8000, 8'd2);
        tick();
        chk("t6_same_cycle", last_ack_cyc - last_beat_cyc, 0);
        chk("t6_busy", busy, 1'b1);
        add_beats(3, -1);
        drain("t6_drain", 30);
        chk("t6_busy_lo", busy, 1'b0);

        // reset mid-operation: stale R beats flag err_len
        add_req(64'h9000, 8'd5); add_req(64'hA000, 8'd5);
        wait_reqs("t7_acks", 10);
        rst_n = 0;
        run(2);
        req_q.delete(); beat_q.delete();
        rst_n = 1;
        chk("t7_busy_lo", busy, 1'b0);
        add_beats(2, -1);
        drain("t7_drain", 20);
        chk("t7_err_len", err_len, 1'b1);
        pulse_start();

        // randomized traffic
        arready_pol = 2; rvalid_pol = 2; mready_pol = 2;
        for (int r = 0; r < 12; r++) begin
            int nreq = $urandom_range(1, 4);
            logic [7:0] ls[4];
            for (int i = 0; i < nreq; i++) begin
                ls[i] = 8'($urandom_range(0, 20));
                add_req(64'($urandom_range(0, 4095)) << 12, ls[i]);
            end
            wait_reqs("rnd_acks", 100);
            for (int i = 0; i < nreq; i++) begin
                int nb = int'(ls[i]) + 1;
                if ($urandom_range(0, 7) == 0) nb = nb + ($urandom_range(0, 1) ? 1 : -1);
                if (nb < 1) nb = 1;
                add_beats(nb, ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1);
            end
            drain("rnd_drain", 1000);
            if ($urandom_range(0, 2) == 0) pulse_start();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
